// File: rtl/conv1d_k1_seq.sv
// Sequencer for the pointwise two-channel conv unit. It reads a frame from the sample RAM,
// passes each sample through the conv unit and streams the results through a credit-protected FIFO.
module conv1d_k1_seq #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] len,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data0,
    input  logic [DATA_WIDTH-1:0] rd_data1,
    output logic                  conv_en,
    output logic [DATA_WIDTH-1:0] conv_din0,
    output logic [DATA_WIDTH-1:0] conv_din1,
    input  logic                  conv_valid,
    input  logic [DATA_WIDTH-1:0] conv_dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam int unsigned ENT_W = DATA_WIDTH + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] len_q;
    logic [ADDR_WIDTH-1:0] issue_cnt;
    logic                  s1_vld, s1_last;
    logic                  s2_vld, s2_last;
    logic                  last_popped;
    logic [ENT_W-1:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      fifo_count;
    logic [1:0]            inflight;
    logic                  fifo_full;
    logic                  credit;
    logic                  issue;
    logic                  issue_last;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic [ENT_W-1:0]      head;

    // Tokens in the RAM and conv stages each reserve one FIFO slot.
    assign inflight   = {1'b0, s1_vld} + {1'b0, s2_vld};
    assign credit     = (SUM_W'(fifo_count) + SUM_W'(inflight)) < SUM_W'(FIFO_DEPTH);
    assign issue_last = (issue_cnt == (len_q - ADDR_WIDTH'(1)));
    assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = (len != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (credit) begin
                    issue = 1'b1;
                    if (issue_last) state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (inflight == 2'd0 && fifo_count == '0 && last_popped) state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign rd_en     = issue;
    assign rd_addr   = issue ? issue_cnt : '0;
    assign conv_en   = s1_vld;
    assign conv_din0 = s1_vld ? rd_data0 : '0;
    assign conv_din1 = s1_vld ? rd_data1 : '0;

    assign push    = conv_valid && s2_vld;
    assign head    = fifo_mem[rd_ptr];
    assign m_valid = (fifo_count != '0);
    assign pop     = m_valid && m_ready;
    assign m_data  = m_valid ? head[DATA_WIDTH-1:0] : '0;
    assign m_last  = m_valid && head[DATA_WIDTH];

    // Issue counter, token pipe, error flag and FIFO bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q       <= '0;
            issue_cnt   <= '0;
            s1_vld      <= 1'b0;
            s1_last     <= 1'b0;
            s2_vld      <= 1'b0;
            s2_last     <= 1'b0;
            last_popped <= 1'b0;
            err         <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
        end else begin
            if (accept) begin
                len_q     <= len;
                issue_cnt <= '0;
            end else if (issue) begin
                issue_cnt <= issue_cnt + ADDR_WIDTH'(1);
            end
            s1_vld  <= issue;
            s1_last <= issue && issue_last;
            s2_vld  <= s1_vld;
            s2_last <= s1_last;
            if (conv_valid && !s2_vld) err <= 1'b1;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                if (head[DATA_WIDTH]) last_popped <= 1'b1;
            end
            if (accept) last_popped <= 1'b0;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {s2_last, conv_dout};
    end

    // The credit rule makes a push into a full FIFO unreachable.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));

endmodule

// File: tb/tb_conv1d_k1_seq.sv
// Bench for conv1d_k1_seq: sample RAM and conv-unit models, a result scoreboard,
// and directed frames covering stalls, aborts and back-to-back starts.
module tb_conv1d_k1_seq;
    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] len;
    logic          busy, done, err;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data0, rd_data1;
    logic          conv_en;
    logic [DW-1:0] conv_din0, conv_din1;
    logic          conv_valid;
    logic [DW-1:0] conv_dout;
    logic          m_valid, m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;

    conv1d_k1_seq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .busy(busy), .done(done), .err(err),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data0(rd_data0), .rd_data1(rd_data1),
        .conv_en(conv_en), .conv_din0(conv_din0), .conv_din1(conv_din1),
        .conv_valid(conv_valid), .conv_dout(conv_dout),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    always #5 clk = ~clk;

    // Conv unit with default weights (3,5) and a >>5 fixed-point scale.
    function automatic logic [DW-1:0] conv_ref(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int sa, sb, s;
        sa = int'($signed(a));
        sb = int'($signed(b));
        s  = (3 * sa + 5 * sb) >>> 5;
        return s[DW-1:0];
    endfunction

    logic [DW-1:0] ram0 [256];
    logic [DW-1:0] ram1 [256];

    always @(posedge clk) begin
        if (rd_en) begin
            rd_data0 <= ram0[rd_addr];
            rd_data1 <= ram1[rd_addr];
        end
    end

    always @(posedge clk) begin
        conv_valid <= conv_en;
        conv_dout  <= conv_ref(conv_din0, conv_din1);
    end

    // 0: always ready, 1: stalled, 2: toggle every cycle.
    int ready_mode = 0;
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = 1'b0;
                default: m_ready = ~m_ready;
            endcase
        end
    end

    // Monitor: per-frame statistics and captured results, sampled on the falling edge.
    int cyc = 0;
    int rd_cnt, rd_first, rd_last, addr_bad, mv_first;
    int busy_cnt, done_cnt, pop_at_done, pop_cnt, max_out;
    logic [DW:0] act_mem [1024];
    int act_wr = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (start && !busy) begin
                rd_cnt = 0; rd_first = -1; rd_last = -1; addr_bad = 0; mv_first = -1;
                busy_cnt = 0; done_cnt = 0; pop_at_done = -1; pop_cnt = 0; max_out = 0;
            end
            if (rd_en) begin
                if (rd_first < 0) rd_first = cyc;
                rd_last = cyc;
                if (int'(rd_addr) != rd_cnt) addr_bad++;
                rd_cnt++;
            end
            if (m_valid && mv_first < 0) mv_first = cyc;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                pop_at_done = pop_cnt;
            end
            if (m_valid && m_ready) begin
                act_mem[act_wr] = {m_last, m_data};
                act_wr++;
                pop_cnt++;
            end
            if (rd_cnt - pop_cnt > max_out) max_out = rd_cnt - pop_cnt;
        end
        cyc++;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int act_rd   = 0;
    logic [DW:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic compare_outputs();
        logic [DW:0] a, e;
        while (act_rd < act_wr) begin
            a = act_mem[act_rd];
            act_rd++;
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'(a[DW-1:0]), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("m_data", 32'(a[DW-1:0]), 32'(e[DW-1:0]));
                check("m_last", 32'(a[DW]), 32'(e[DW]));
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            compare_outputs();
        end
    endtask

    task automatic push_expected(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), conv_ref(ram0[i], ram1[i])});
    endtask

    task automatic start_frame(input int n);
        start = 1'b1;
        len   = AW'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            step(1);
            k++;
        end
        check("done_seen", 32'(done_cnt != 0), 32'd1);
    endtask

    task automatic randomize_ram();
        for (int i = 0; i < 256; i++) begin
            ram0[i] = DW'($urandom);
            ram1[i] = DW'($urandom);
        end
    endtask

    typedef struct {
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic [DW-1:0] exp_data;
        logic          exp_last;
    } vec_t;
    vec_t tv [4];

    initial begin
        tv[0] = '{16'd32,     16'd32, 16'd8,  1'b0};
        tv[1] = '{16'd64,     16'd0,  16'd6,  1'b0};
        tv[2] = '{16'd0,      16'd64, 16'd10, 1'b0};
        tv[3] = '{16'hFFE0,   16'd32, 16'd2,  1'b1};

        rst = 1'b1; start = 1'b0; len = '0;
        randomize_ram();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_done",    32'(done),    32'd0);
        check("rst_err",     32'(err),     32'd0);
        check("rst_rd_en",   32'(rd_en),   32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_conv_en", 32'(conv_en), 32'd0);
        check("rst_din0",    32'(conv_din0), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data",  32'(m_data),  32'd0);
        check("rst_m_last",  32'(m_last),  32'd0);
        rst = 1'b0;
        step(2);

        // Table frame with known results, always ready.
        for (int i = 0; i < 4; i++) begin
            ram0[i] = tv[i].d0;
            ram1[i] = tv[i].d1;
            exp_q.push_back({tv[i].exp_last, tv[i].exp_data});
        end
        start_frame(4);
        wait_done(60);
        step(2);
        check("t1_rd_count",     32'(rd_cnt), 32'd4);
        check("t1_rd_span",      32'(rd_last - rd_first), 32'd3);
        check("t1_addr",         32'(addr_bad), 32'd0);
        check("t1_latency",      32'(mv_first - rd_first), 32'd3);
        check("t1_done_cycles",  32'(done_cnt), 32'd1);
        check("t1_pops",         32'(pop_cnt), 32'd4);
        check("t1_busy_after",   32'(busy), 32'd0);

        // Downstream stalled for 20 cycles: credit stops issue at FIFO depth.
        randomize_ram();
        ready_mode = 1;
        step(2);
        push_expected(8);
        start_frame(8);
        step(20);
        check("t2_issue_stall",  32'(rd_cnt), DEPTH);
        check("t2_m_valid_held", 32'(m_valid), 32'd1);
        check("t2_no_err_stall", 32'(err), 32'd0);
        ready_mode = 0;
        wait_done(100);
        step(2);
        check("t2_pops",     32'(pop_cnt), 32'd8);
        check("t2_rd_count", 32'(rd_cnt), 32'd8);
        check("t2_addr",     32'(addr_bad), 32'd0);
        check("t2_err",      32'(err), 32'd0);
        check("t2_max_occ",  32'(max_out <= int'(DEPTH)), 32'd1);

        // Ready toggling every cycle.
        randomize_ram();
        push_expected(6);
        ready_mode = 2;
        start_frame(6);
        wait_done(100);
        step(2);
        ready_mode = 0;
        check("t3_pops",         32'(pop_cnt), 32'd6);
        check("t3_done_after",   32'(pop_at_done), 32'd6);
        check("t3_max_occ",      32'(max_out <= int'(DEPTH)), 32'd1);
        check("t3_err",          32'(err), 32'd0);
        check("t3_queue_empty",  32'(exp_q.size()), 32'd0);
        step(2);

        // Empty frame.
        start_frame(0);
        step(3);
        check("t4_rd_count", 32'(rd_cnt), 32'd0);
        check("t4_done",     32'(done_cnt), 32'd1);
        check("t4_busy",     32'(busy_cnt), 32'd1);

        // Start while busy is ignored; then a back-to-back frame right after done.
        randomize_ram();
        push_expected(3);
        start_frame(3);
        step(1);
        start = 1'b1;
        len   = AW'(7);
        step(1);
        start = 1'b0;
        wait_done(60);
        check("t5_rd_count", 32'(rd_cnt), 32'd3);
        check("t5_pops",     32'(pop_cnt), 32'd3);
        for (int i = 0; i < 3; i++) begin
            ram0[i] = DW'($urandom);
            ram1[i] = DW'($urandom);
        end
        push_expected(3);
        start_frame(3);
        check("t6_accepted", 32'(busy), 32'd1);
        wait_done(60);
        step(2);
        check("t6_rd_count", 32'(rd_cnt), 32'd3);
        check("t6_addr",     32'(addr_bad), 32'd0);
        check("t6_pops",     32'(pop_cnt), 32'd3);
        check("t6_err",      32'(err), 32'd0);

        // Reset mid-frame: abort, stray conv result flags err.
        randomize_ram();
        push_expected(5);
        start_frame(5);
        begin
            int k = 0;
            while (!conv_en && k < 10) begin
                step(1);
                k++;
            end
        end
        check("t7_conv_en_seen", 32'(conv_en), 32'd1);
        step(1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t7_rd_en",   32'(rd_en), 32'd0);
        check("t7_conv_en", 32'(conv_en), 32'd0);
        check("t7_busy",    32'(busy), 32'd0);
        check("t7_m_valid", 32'(m_valid), 32'd0);
        check("t7_done",    32'(done), 32'd0);
        check("t7_err_low", 32'(err), 32'd0);
        step(1);
        check("t7_err_set", 32'(err), 32'd1);
        exp_q.delete();
        compare_outputs();
        step(2);
        push_expected(2);
        start_frame(2);
        wait_done(60);
        step(2);
        check("t7_pops",        32'(pop_cnt), 32'd2);
        check("t7_err_sticky",  32'(err), 32'd1);
        check("t7_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/conv1d_k1_seq.md
Name: conv1d_k1_seq

Overview:
Sequencer for the pointwise (k=1) two-input-channel conv unit.
- On start, it reads a frame of len two-channel samples from a sample RAM with 1-cycle read latency.
- It issues each sample to the conv unit through en/din0/din1 and collects the results.
- Results leave on a valid/ready output stream, with last marking the final sample of the frame.
- Credit-based issue guarantees no result is lost when the downstream consumer stalls. The conv unit has no stall input.

Parameters:
DATA_WIDTH, 16, sample and result width.
ADDR_WIDTH, 8, sample RAM address width; max frame = 2^ADDR_WIDTH-1.
FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2).

Ports:
clk  in  1  clock, all logic on posedge.
rst  in  1  synchronous active-high reset.
start  in  1  one-cycle request to begin a frame; ignored unless idle.
len  in  ADDR_WIDTH  frame length, sampled when start is accepted.
busy  out  1  high from accepted start until done.
done  out  1  one-cycle pulse at frame completion.
err  out  1  sticky: conv result arrived with no matching issue; cleared only by rst.
rd_en  out  1  sample RAM read strobe.
rd_addr  out  ADDR_WIDTH  sample RAM address, 0..len-1.
rd_data0  in  DATA_WIDTH  channel-0 sample, valid the cycle after rd_en.
rd_data1  in  DATA_WIDTH  channel-1 sample, valid the cycle after rd_en.
conv_en  out  1  conv unit enable.
conv_din0  out  DATA_WIDTH  conv channel-0 input.
conv_din1  out  DATA_WIDTH  conv channel-1 input.
conv_valid  in  1  conv result valid; 1 cycle after conv_en.
conv_dout  in  DATA_WIDTH  conv result.
m_valid  out  1  output stream valid.
m_ready  in  1  output stream ready.
m_data  out  DATA_WIDTH  output result.
m_last  out  1  high with the frame's final result.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE; issue counter, FIFO pointers/count and in-flight tokens cleared.
  - err cleared.
- States:
  - IDLE:
    - start with len>0: latch len, go to RUN.
    - start with len==0: go to DONE with no reads.
  - RUN:
    - Assert rd_en with rd_addr=issue count when credit is available.
    - Credit rule: fifo_count + inflight < FIFO_DEPTH. inflight = issue tokens in the 2-stage pipe.
    - After issue len-1 the state goes to DRAIN.
  - DRAIN:
    - No reads.
    - Go to DONE when inflight==0, the FIFO is empty, and the last result was popped.
  - DONE: done=1 for exactly one cycle, then IDLE.
- busy is 1 in RUN and DRAIN, and is also 1 in DONE.
- start while busy is ignored.
- Issue pipe:
  - conv_en is rd_en delayed by 1 cycle.
  - conv_din0/1 are rd_data0/1 passed through combinationally that cycle.
  - conv_din0/1 are held 0 when conv_en=0.
  - A token register carries the last flag alongside the conv stage (2 stages: RAM, conv).
- Latency: rd_en at cycle t -> conv_en at t+1 -> conv_valid at t+2 -> FIFO write at t+2 -> m_valid at t+3 earliest.
- Capture:
  - conv_valid with a token in stage 2: write {last, conv_dout} to the FIFO.
  - conv_valid with no token: discard and set err. This covers results arriving after rst.
- FIFO:
  - m_valid = !empty; m_data/m_last come from the head entry.
  - Pop on m_valid && m_ready.
  - Simultaneous push and pop keeps the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Overflow is impossible by the credit rule. A push while full is an assertion failure.
- rst mid-frame: everything aborts the next cycle with no done pulse. Data still in the conv pipe is discarded and sets err.
- Widths: no arithmetic on data; the counter is ADDR_WIDTH bits and compares against the latched len.

Test Plan:
- rst, then start with len=4; RAM holds pairs (32,32),(64,0),(0,64),(-32,32); conv unit at default weights (3,5); m_ready=1 -> m_data 8,6,10,2 in order, m_last only on the 4th, rd_en 4 consecutive cycles, first m_valid 3 cycles after first rd_en, done 1 cycle.
- len=8, m_ready=0 for 20 cycles then 1 -> rd_en stops after exactly FIFO_DEPTH=4 issues, no err, all 8 results delivered in order, last on the 8th.
- len=6, m_ready toggling 1/0 every cycle -> 6 results in order, fifo_count never exceeds 4, done only after the 6th pop.
- start with len=0 -> no rd_en, done pulse the cycle after DONE entry, busy high for 1 cycle; start asserted while busy in another frame -> ignored, len unchanged.
- rst asserted 1 cycle after conv_en during a len=5 frame -> outputs 0 next cycle, the stray conv_valid sets err=1; a following start len=2 completes normally with err still 1.
- Back-to-back frames: start len=3 on the cycle after done -> accepted, rd_addr restarts at 0, m_last on the 3rd result of the second frame.
